// File: rtl/stereo_audio_serializer_if.sv
// Purpose: valid/ready bundle for the stereo pair -> serial channel word serializer.
//   Input side : i_valid, i_ready, i_left, i_right (one stereo pair per transfer)
//   Output side: o_valid, o_ready, o_is_left, o_audio (one channel word per transfer)
// Modports: slave = the serializer, master = the surrounding logic that feeds it
//   pairs and drains its words.
interface stereo_audio_serializer_if #(
  parameter int unsigned audio_width = 32
) ();

  logic                   i_valid;
  logic                   i_ready;
  logic [audio_width-1:0] i_left;
  logic [audio_width-1:0] i_right;

  logic                   o_valid;
  logic                   o_ready;
  logic                   o_is_left;
  logic [audio_width-1:0] o_audio;

  modport slave (
    input  i_valid,
    input  i_left,
    input  i_right,
    output i_ready,
    output o_valid,
    input  o_ready,
    output o_is_left,
    output o_audio
  );

  modport master (
    output i_valid,
    output i_left,
    output i_right,
    input  i_ready,
    input  o_valid,
    output o_ready,
    input  o_is_left,
    input  o_audio
  );

endinterface

// File: rtl/stereo_audio_serializer.sv
// Purpose: splits each accepted stereo pair into two single-channel words tagged
//   with a left/right flag, in acceptance order. A one-pair pending buffer lets a
//   new pair be taken while the current one is still being emitted, so a steady
//   stream produces one word per cycle.
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - slave side of stereo_audio_serializer_if
//              (i_valid/i_ready/i_left/i_right in, o_valid/o_ready/o_is_left/o_audio out)
// Parameters:
//   audio_width - bits per channel sample
//   left_first  - 1: left word then right word; 0: right then left
module stereo_audio_serializer #(
  parameter int unsigned audio_width = 32,
  parameter bit          left_first  = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  stereo_audio_serializer_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t                 state;
  logic [audio_width-1:0] cur_left;
  logic [audio_width-1:0] cur_right;
  logic [audio_width-1:0] pend_left;
  logic [audio_width-1:0] pend_right;
  logic                   pend_full;

  logic                   accept;
  logic                   handshake;
  logic                   present_left;

  // Ready comes straight from the pending flag so it never depends on the
  // same-cycle input valid or downstream ready.
  assign bus.i_ready = ~pend_full;
  assign accept      = bus.i_valid & ~pend_full;
  assign handshake   = (state != EMPTY) & bus.o_ready;

  // Output mux of registers only; in EMPTY this falls through to cur_right.
  assign present_left  = left_first ? (state == FIRST) : (state == SECOND);
  assign bus.o_valid   = (state != EMPTY);
  assign bus.o_is_left = present_left;
  assign bus.o_audio   = present_left ? cur_left : cur_right;

  // State, current pair and pending pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      cur_left   <= '0;
      cur_right  <= '0;
      pend_left  <= '0;
      pend_right <= '0;
      pend_full  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            cur_left  <= bus.i_left;
            cur_right <= bus.i_right;
            state     <= FIRST;
          end
        end

        FIRST: begin
          // Current pair is mid-emission: a new pair can only park in pending.
          if (accept) begin
            pend_left  <= bus.i_left;
            pend_right <= bus.i_right;
            pend_full  <= 1'b1;
          end
          if (handshake) begin
            state <= SECOND;
          end
        end

        SECOND: begin
          if (handshake) begin
            if (pend_full) begin
              cur_left  <= pend_left;
              cur_right <= pend_right;
              pend_full <= 1'b0;
              state     <= FIRST;
            end else if (accept) begin
              // Pending is empty: take the arriving pair straight into cur.
              cur_left  <= bus.i_left;
              cur_right <= bus.i_right;
              state     <= FIRST;
            end else begin
              state <= EMPTY;
            end
          end else if (accept) begin
            pend_left  <= bus.i_left;
            pend_right <= bus.i_right;
            pend_full  <= 1'b1;
          end
        end

        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule
